// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for blocks that sit on the read side of sync_fifo.
//   state_t         : reader FSM state encoding (IDLE / BURST / FLUSH)
//   clamp_burst_len : maps a raw burst-length request onto 1..depth
// -----------------------------------------------------------------------------
package fifo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   // A request of 0 still moves one word; anything above the FIFO depth could
   // never be satisfied by the almost-empty flag, so it is pulled down to depth.
   function automatic int unsigned clamp_burst_len(input int unsigned raw,
                                                   input int unsigned depth);
      if (raw == 0) begin
         return 1;
      end else if (raw > depth) begin
         return depth;
      end else begin
         return raw;
      end
   endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader_if
// Bundles the two handshakes of fifo_burst_reader.
//   FIFO side   : i_valid_m, i_fifo_data, i_almostempty (in), o_ready_m (out)
//   stream side : o_valid, o_data, o_last (out), i_ready (in)
// Handshake rule on both sides: a word moves on a rising clock edge where
// valid and ready are both 1; once raised, valid/data hold until that edge.
// Modports:
//   master : the reader itself (i_* inputs, o_* outputs)
//   slave  : the environment (FIFO + downstream consumer)
// -----------------------------------------------------------------------------
interface fifo_burst_reader_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  i_valid_m;
   logic [DATA_WIDTH-1:0] i_fifo_data;
   logic                  i_almostempty;
   logic                  o_ready_m;
   logic                  o_valid;
   logic                  i_ready;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_last;

   modport master (
      input  i_valid_m, i_fifo_data, i_almostempty, i_ready,
      output o_ready_m, o_valid, o_data, o_last
   );

   modport slave (
      output i_valid_m, i_fifo_data, i_almostempty, i_ready,
      input  o_ready_m, o_valid, o_data, o_last
   );
endinterface

// File: rtl/stream_out_reg.sv
// -----------------------------------------------------------------------------
// stream_out_reg
// One-entry valid/ready output register.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : capture i_din this edge (caller guarantees slot is free)
//   i_din          : payload to capture
//   i_ready        : downstream accepts the held payload this edge
//   o_valid        : payload held
//   o_dout         : held payload, stable while o_valid & ~i_ready
// -----------------------------------------------------------------------------
module stream_out_reg #(
   parameter int W = 33
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_din,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_dout
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_dout  <= '0;
      end else if (i_load) begin
         o_valid <= 1'b1;
         o_dout  <= i_din;
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
// Drains a first-word-fall-through sync_fifo and re-emits its words as
// fixed-length bursts with a last marker. Residual words that never reach a
// full burst are flushed as single-beat bursts after a programmable idle time.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : FIFO-side and stream-side handshakes (master modport)
//   i_burst_len    : burst length, clamped to 1..FIFO_DEPTH, latched per burst
//   i_timeout      : idle cycles before a flush; 0 disables flushing
//   o_busy         : FSM active or an output word pending
//   o_flush        : FSM is draining residual words
//   o_dbg_state    : current FSM state
// -----------------------------------------------------------------------------
module fifo_burst_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int AW         = $clog2(FIFO_DEPTH),
   parameter int TW         = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   fifo_burst_reader_if.master bus,
   input  logic [AW:0]         i_burst_len,
   input  logic [TW-1:0]       i_timeout,
   output logic                o_busy,
   output logic                o_flush,
   output state_t              o_dbg_state
);

   state_t          state_q, state_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic [AW:0]     len_q, len_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [AW:0]     eff_len;
   logic            slot_free;
   logic            pop;
   logic            beat_last;
   logic            out_valid;
   logic            out_last;
   logic [DATA_WIDTH-1:0] out_data;

   assign eff_len = (AW+1)'(clamp_burst_len(32'(i_burst_len), 32'(FIFO_DEPTH)));

   // The output slot is free when empty or being drained this edge; the FIFO
   // request deliberately ignores i_valid_m so it never loops back into it.
   assign slot_free     = ~out_valid | bus.i_ready;
   assign bus.o_ready_m = (state_q != ST_IDLE) & slot_free;
   assign pop           = bus.o_ready_m & bus.i_valid_m;

   // Flushed words are always single-beat bursts.
   assign beat_last = (state_q == ST_FLUSH) | (cnt_q == len_q - (AW+1)'(1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         len_q   <= (AW+1)'(1);
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      timer_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_valid_m && !bus.i_almostempty) begin
               state_d = ST_BURST;
               len_d   = eff_len;
               cnt_d   = '0;
            end else if ((i_timeout != '0) && (timer_q == i_timeout)) begin
               state_d = ST_FLUSH;
            end else if (bus.i_valid_m) begin
               // Reaching here with data means almost-empty is set: the
               // residue is too small for a burst, so count idle time.
               timer_d = (timer_q == '1) ? timer_q : timer_q + TW'(1);
            end
         end
         ST_BURST: begin
            if (pop) begin
               if (beat_last) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + (AW+1)'(1);
               end
            end
         end
         ST_FLUSH: begin
            if (!bus.i_valid_m && slot_free) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   stream_out_reg #(
      .W (DATA_WIDTH + 1)
   ) u_out (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (pop),
      .i_din   ({bus.i_fifo_data, beat_last}),
      .i_ready (bus.i_ready),
      .o_valid (out_valid),
      .o_dout  ({out_data, out_last})
   );

   assign bus.o_valid = out_valid;
   assign bus.o_data  = out_data;
   assign bus.o_last  = out_last;

   assign o_busy      = (state_q != ST_IDLE) | out_valid;
   assign o_flush     = (state_q == ST_FLUSH);
   assign o_dbg_state = state_q;

endmodule
